// File: rtl/ifetch_byte_asm.sv
// rtl/ifetch_byte_asm.sv - two-beat byte-assembling instruction fetch from a dual-port 8-bit BRAM
//
// Purpose:
//   Fetches 32-bit instructions from a byte-wide, read-only dual-port BRAM.
//   Each fetch uses two read beats: beat one reads bytes 0 and 1, beat two
//   reads bytes 2 and 3. The bytes are assembled little-endian and the word is
//   handed to decode with a valid/ready handshake. A redirect flushes any
//   in-flight fetch and restarts at the new (word-aligned) PC.
//
// Ports:
//   clk                  clock; also clocks both BRAM ports
//   rst                  synchronous reset, active high
//   redirect_valid/pc    branch/jump target from execute
//   mem_ena/enb          BRAM port enables (high only in the two issue cycles)
//   mem_wea/web          BRAM write enables, tied low (fetch never writes)
//   mem_addra/addrb      BRAM byte addresses
//   mem_douta/doutb      BRAM read data, one cycle after the address
//   inst_valid/ready     handshake to decode
//   inst, inst_pc        assembled word and its byte address
//   misalign_err         one-cycle pulse after a non-word-aligned redirect
module ifetch_byte_asm #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_ena,
  output logic              mem_enb,
  output logic              mem_wea,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [ADDR_W-1:0] mem_addrb,
  input  logic [7:0]        mem_douta,
  input  logic [7:0]        mem_doutb,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              misalign_err
);

  typedef enum logic [1:0] {ISSUE_LO, ISSUE_HI, COLLECT, VALID} state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [15:0]       lo_half;
  logic [ADDR_W-1:0] pc_base;
  logic              issue;

  // Only the low ADDR_W bits address the BRAM; the upper PC bits ride along
  // into inst_pc. pc is word-aligned, so base+3 never crosses the wrap.
  assign pc_base = pc[ADDR_W-1:0];

  assign mem_wea = 1'b0;
  assign mem_web = 1'b0;

  always_comb begin
    issue     = (state == ISSUE_LO) || (state == ISSUE_HI);
    mem_ena   = issue && !rst;
    mem_enb   = issue && !rst;
    mem_addra = pc_base;
    mem_addrb = pc_base + ADDR_W'(1);
    if (state == ISSUE_HI) begin
      mem_addra = pc_base + ADDR_W'(2);
      mem_addrb = pc_base + ADDR_W'(3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ISSUE_LO;
      pc           <= RESET_PC;
      lo_half      <= 16'h0000;
      inst_valid   <= 1'b0;
      inst         <= 32'h0000_0013;
      inst_pc      <= 32'h0000_0000;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (redirect_valid) begin
        // Redirect wins over everything, including a handshake in VALID:
        // a word offered this cycle still counts as accepted by decode.
        // Data returning from an issued beat is simply never latched.
        pc           <= {redirect_pc[31:2], 2'b00};
        inst_valid   <= 1'b0;
        state        <= ISSUE_LO;
        misalign_err <= |redirect_pc[1:0];
      end else begin
        case (state)
          ISSUE_LO: state <= ISSUE_HI;
          ISSUE_HI: begin
            // Data for bytes 0/1 arrives now, one cycle after ISSUE_LO.
            lo_half <= {mem_doutb, mem_douta};
            state   <= COLLECT;
          end
          COLLECT: begin
            inst       <= {mem_doutb, mem_douta, lo_half};
            inst_pc    <= pc;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b1;
            state      <= VALID;
          end
          VALID: begin
            if (inst_valid && inst_ready) begin
              inst_valid <= 1'b0;
              state      <= ISSUE_LO;
            end
          end
          default: state <= ISSUE_LO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_byte_asm.sv
// tb/tb_ifetch_byte_asm.sv - self-checking bench for ifetch_byte_asm
module tb_ifetch_byte_asm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;
  logic        mem_ena, mem_enb, mem_wea, mem_web;
  logic [11:0] mem_addra, mem_addrb;
  logic [7:0]  mem_douta = 8'h00;
  logic [7:0]  mem_doutb = 8'h00;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        misalign_err;

  logic [7:0]  img [0:4095];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  ifetch_byte_asm #(.ADDR_W(12), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_ena(mem_ena), .mem_enb(mem_enb), .mem_wea(mem_wea), .mem_web(mem_web),
    .mem_addra(mem_addra), .mem_addrb(mem_addrb),
    .mem_douta(mem_douta), .mem_doutb(mem_doutb),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Dual-port BRAM with registered one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ena) mem_douta <= img[mem_addra];
    if (mem_enb) mem_doutb <= img[mem_addrb];
  end

  function automatic logic [63:0] exp_entry(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {a, img[b + 12'd3], img[b + 12'd2], img[b + 12'd1], img[b]};
  endfunction

  // Advance one cycle; a word offered with ready high is accepted at this edge.
  task automatic tick();
    if (!rst && inst_valid && inst_ready) obs_q.push_back({inst_pc, inst});
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cycle = 0;
    obs_q.delete();
    exp_q.delete();
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] e, o;
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_005A;
    inst_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({inst_valid, inst, inst_pc, misalign_err} !== {1'b0, 32'h0000_0013, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs actual=%b/%h/%h/%b required=0/00000013/00000000/0",
               inst_valid, inst, inst_pc, misalign_err);
    end
    checks++;
    if ({mem_ena, mem_enb, mem_wea, mem_web} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_enables actual=%b required=0000", {mem_ena, mem_enb, mem_wea, mem_web});
    end
    redirect_valid = 1'b0;
    rst = 1'b0;
    cycle = 0;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(exp_entry(32'h0));
    #1;
    checks++;
    if ({mem_ena, mem_enb, mem_addra, mem_addrb} !== {2'b11, 12'h000, 12'h001}) begin
      failures++;
      $display("FAIL reset_first_issue actual=%b%b/%h/%h required=11/000/001",
               mem_ena, mem_enb, mem_addra, mem_addrb);
    end
    for (int i = 0; i < 4; i++) tick();
    inst_ready = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL reset_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL reset_sb actual=%h required=%h", o, e);
        end
      end
    end
  endtask

  task automatic test_free_run();
    int en_cnt;
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b1;
    en_cnt = 0;
    exp_q.push_back(exp_entry(32'h0));
    exp_q.push_back(exp_entry(32'h4));
    exp_q.push_back(exp_entry(32'h8));
    for (int i = 0; i < 12; i++) begin
      if (cycle < 4 && mem_ena && mem_enb) en_cnt++;
      if (cycle == 2) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL free_c2_valid actual=%b required=0", inst_valid);
        end
      end
      if (cycle == 3 || cycle == 7 || cycle == 11) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !==
            {1'b1, (cycle == 3) ? 32'h00A0_0093 : (cycle == 7) ? 32'h0140_0113 : 32'h00A0_0193,
             (cycle == 3) ? 32'h0 : (cycle == 7) ? 32'h4 : 32'h8}) begin
          failures++;
          $display("FAIL free_word_c%0d actual=%b/%h/%h", cycle, inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    checks++;
    if (en_cnt != 2) begin
      failures++;
      $display("FAIL free_enable_cycles actual=%0d required=2", en_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL free_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL free_sb actual=%h required=%h", o, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b0;
    exp_q.push_back(exp_entry(32'h0));
    exp_q.push_back(exp_entry(32'h4));
    for (int i = 0; i < 13; i++) begin
      if (cycle == 8) inst_ready = 1'b1;
      if (cycle >= 3 && cycle <= 7) begin
        checks++;
        if ({inst_valid, mem_ena, mem_enb, inst} !== {3'b100, 32'h00A0_0093}) begin
          failures++;
          $display("FAIL bp_hold_c%0d actual=%b%b%b/%h required=100/00a00093",
                   cycle, inst_valid, mem_ena, mem_enb, inst);
        end
      end
      if (cycle == 11) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL bp_early_valid actual=%b required=0", inst_valid);
        end
      end
      if (cycle == 12) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0140_0113, 32'h4}) begin
          failures++;
          $display("FAIL bp_next_word actual=%b/%h/%h required=1/01400113/00000004",
                   inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    inst_ready = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL bp_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL bp_sb actual=%h required=%h", o, e);
        end
      end
    end
  endtask

  task automatic test_redirect_mid_fetch();
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b1;
    exp_q.push_back(exp_entry(32'h0));
    exp_q.push_back(exp_entry(32'h58));
    for (int i = 0; i < 10; i++) begin
      redirect_valid = 1'b0;
      if (cycle == 5) begin
        checks++;
        if ({mem_ena, mem_addra, mem_addrb} !== {1'b1, 12'h006, 12'h007}) begin
          failures++;
          $display("FAIL rd_issue_hi actual=%b/%h/%h required=1/006/007", mem_ena, mem_addra, mem_addrb);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0058;
      end
      if (cycle == 6) begin
        checks++;
        if ({mem_ena, mem_addra} !== {1'b1, 12'h058}) begin
          failures++;
          $display("FAIL rd_restart actual=%b/%h required=1/058", mem_ena, mem_addra);
        end
      end
      if (cycle >= 6 && cycle <= 8) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL rd_flushed_c%0d actual=%b required=0", cycle, inst_valid);
        end
      end
      if (cycle == 9) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h01E0_0613, 32'h58}) begin
          failures++;
          $display("FAIL rd_target_word actual=%b/%h/%h required=1/01e00613/00000058",
                   inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL rd_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL rd_sb actual=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rd_extra_words actual=%0d required=0", obs_q.size());
    end
  endtask

  task automatic test_misaligned();
    int pulses;
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b1;
    pulses = 0;
    exp_q.push_back({32'h58, 32'h01E0_0613});
    for (int i = 0; i < 6; i++) begin
      redirect_valid = (cycle == 0);
      redirect_pc = 32'h0000_005A;
      if (misalign_err) pulses++;
      if (cycle == 1) begin
        checks++;
        if ({misalign_err, mem_addra} !== {1'b1, 12'h058}) begin
          failures++;
          $display("FAIL mis_pulse actual=%b/%h required=1/058", misalign_err, mem_addra);
        end
      end
      if (cycle == 4) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h01E0_0613, 32'h58}) begin
          failures++;
          $display("FAIL mis_word actual=%b/%h/%h required=1/01e00613/00000058",
                   inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL mis_pulse_len actual=%0d required=1", pulses);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL mis_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL mis_sb actual=%h required=%h", o, e);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b1;
    exp_q.push_back({32'h0000_0FFC, 32'h0000_0013});
    exp_q.push_back({32'h0000_1000, 32'h00A0_0093});
    for (int i = 0; i < 9; i++) begin
      redirect_valid = (cycle == 0);
      redirect_pc = 32'h0000_0FFC;
      if (cycle == 1 || cycle == 2) begin
        checks++;
        if ({mem_addra, mem_addrb} !== ((cycle == 1) ? {12'hFFC, 12'hFFD} : {12'hFFE, 12'hFFF})) begin
          failures++;
          $display("FAIL wrap_addr_c%0d actual=%h/%h", cycle, mem_addra, mem_addrb);
        end
      end
      if (cycle == 4) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0013, 32'hFFC}) begin
          failures++;
          $display("FAIL wrap_last_word actual=%b/%h/%h required=1/00000013/00000ffc",
                   inst_valid, inst, inst_pc);
        end
      end
      if (cycle == 5) begin
        checks++;
        if ({mem_ena, mem_addra, mem_addrb} !== {1'b1, 12'h000, 12'h001}) begin
          failures++;
          $display("FAIL wrap_issue_lo actual=%b/%h/%h required=1/000/001", mem_ena, mem_addra, mem_addrb);
        end
      end
      if (cycle == 8) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h00A0_0093, 32'h1000}) begin
          failures++;
          $display("FAIL wrap_next_word actual=%b/%h/%h required=1/00a00093/00001000",
                   inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL wrap_sb actual=%h required=%h", o, e);
        end
      end
    end
  endtask

  task automatic test_reset_collect();
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_ena, mem_enb, inst_valid} !== 3'b000) begin
      failures++;
      $display("FAIL rc_collect actual=%b%b%b required=000", mem_ena, mem_enb, inst_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({inst_valid, inst, mem_ena} !== {1'b0, 32'h0000_0013, 1'b0}) begin
      failures++;
      $display("FAIL rc_aborted actual=%b/%h/%b required=0/00000013/0", inst_valid, inst, mem_ena);
    end
    rst = 1'b0;
    cycle = 0;
    #1;
    exp_q.push_back(exp_entry(32'h0));
    for (int i = 0; i < 4; i++) begin
      if (cycle == 3) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h00A0_0093, 32'h0}) begin
          failures++;
          $display("FAIL rc_restart actual=%b/%h/%h required=1/00a00093/00000000",
                   inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    inst_ready = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL rc_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL rc_sb actual=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rc_extra_words actual=%0d required=0", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e, o;
    apply_reset();
    inst_ready = 1'b1;
    exp_q.push_back(exp_entry(32'h0));
    exp_q.push_back(exp_entry(32'h58));
    exp_q.push_back(exp_entry(32'h5C));
    for (int i = 0; i < 12; i++) begin
      redirect_valid = (cycle == 3);
      redirect_pc = 32'h0000_0058;
      if (cycle == 4) begin
        checks++;
        if ({inst_valid, mem_addra} !== {1'b0, 12'h058}) begin
          failures++;
          $display("FAIL b2b_restart actual=%b/%h required=0/058", inst_valid, mem_addra);
        end
      end
      if (cycle == 7) begin
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h01E0_0613, 32'h58}) begin
          failures++;
          $display("FAIL b2b_target actual=%b/%h/%h required=1/01e00613/00000058",
                   inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_sb actual=none required=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL b2b_sb actual=%h required=%h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_extra_words actual=%0d required=0", obs_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) img[i] = 8'(i * 37 + 11);
    {img[3], img[2], img[1], img[0]}             = 32'h00A0_0093;
    {img[7], img[6], img[5], img[4]}             = 32'h0140_0113;
    {img[11], img[10], img[9], img[8]}           = 32'h00A0_0193;
    {img[91], img[90], img[89], img[88]}         = 32'h01E0_0613;
    {img[4095], img[4094], img[4093], img[4092]} = 32'h0000_0013;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_mid_fetch();
    test_misaligned();
    test_wrap();
    test_reset_collect();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_byte_asm.md
# ifetch_byte_asm

Instruction fetch stage that sits directly downstream of the 4096×8 dual-port instruction BRAM. It drives both BRAM ports read-only and fetches the four bytes of each 32-bit instruction over two read beats. Each beat reads two bytes, one per port. The bytes are assembled little-endian into a word, which is presented to decode with a valid/ready handshake. A redirect input (branch/jump target from execute) flushes any in-flight fetch and restarts at the new PC.

## Interface
- `ADDR_W`, default 12: BRAM byte-address width.
- `RESET_PC`, default 32'h0000_0000: PC after reset. Must be word-aligned.
- `clk` in 1: the single clock. It also drives the BRAM `clka`/`clkb`.
- `rst` in 1: synchronous reset, active-high.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_pc` in 32: target byte address.
- `mem_ena`, `mem_enb` out 1: BRAM port enables.
- `mem_addra`, `mem_addrb` out ADDR_W: BRAM byte addresses.
- `mem_douta`, `mem_doutb` in 8: BRAM read data, with a registered 1-cycle latency.
- Top level ties BRAM `wea`/`web` to 0.
- `inst_valid` out 1: `inst` and `inst_pc` are valid.
- `inst_ready` in 1: decode accepts the word.
- `inst` out 32: assembled instruction.
- `inst_pc` out 32: byte address of `inst`.
- `misalign_err` out 1: one-cycle pulse when a redirect target is not word-aligned.

## Operation
- Registers:
  - `pc` (32 bits).
  - `lo_half` (16 bits).
  - `state`, one of ISSUE_LO, ISSUE_HI, COLLECT, VALID.
- ISSUE_LO:
  - Drive `mem_ena=mem_enb=1`, `mem_addra=pc[ADDR_W-1:0]`, `mem_addrb=pc+1`.
  - Go to ISSUE_HI.
- ISSUE_HI:
  - Drive enables, with `mem_addra=pc+2` and `mem_addrb=pc+3`.
  - Latch `lo_half <= {mem_doutb, mem_douta}` (bytes 1,0).
  - Go to COLLECT.
- COLLECT:
  - Enables are 0.
  - `inst <= {mem_doutb, mem_douta, lo_half}`, `inst_pc <= pc`, `pc <= pc+4`, `inst_valid <= 1`.
  - Go to VALID.
- VALID:
  - Enables are 0. `inst` and `inst_pc` stay stable while `inst_ready=0`.
  - On `inst_valid & inst_ready`: `inst_valid <= 0` and go to ISSUE_LO.
- Address arithmetic:
  - Memory addresses are `pc[ADDR_W-1:0]+k` modulo 2^ADDR_W.
  - Because `pc` is aligned, the four bytes never straddle the wrap.
  - `pc` itself increments modulo 2^32. High PC bits are carried in `inst_pc` but ignored for addressing.
- Redirect has priority over every state and over the handshake:
  - `pc <= {redirect_pc[31:2], 2'b00}`, `inst_valid <= 0`, state goes to ISSUE_LO.
  - In-flight BRAM data is discarded.
  - If `redirect_pc[1:0] != 0`, `misalign_err` is 1 in the following cycle only.
- Redirect in the same cycle as a handshake in VALID: the current word counts as accepted, and fetch restarts from the redirect target.
- Reset:
  - Values: `pc=RESET_PC`, state=ISSUE_LO, `inst_valid=0`, `inst=32'h0000_0013` (NOP), `inst_pc=0`, `lo_half=0`, `misalign_err=0`.
  - `mem_ena=mem_enb=0` while `rst=1`.
  - Reset overrides redirect.
  - Reset in any state, including mid-COLLECT, aborts the fetch with no partial word emitted.

## Timing
- Cycle 0 is the first cycle with `rst=0`. Cycle 0 is ISSUE_LO, cycle 1 is ISSUE_HI, cycle 2 is COLLECT.
- `inst_valid=1` from cycle 3.
- Handshake in cycle n puts ISSUE_LO in cycle n+1 and the next `inst_valid` in cycle n+4.
- With `inst_ready` held at 1, throughput is one instruction per 4 cycles.
- Redirect sampled in cycle n puts ISSUE_LO in cycle n+1 at the target, with first `inst_valid` in cycle n+4.
- Memory enables are asserted only in ISSUE_LO and ISSUE_HI, so there are exactly 2 enable cycles per fetch.

## Test plan
- **Reset, then free run.** Release reset with `inst_ready=1` and BRAM preloaded with the branch-test image.
  - Cycle 3: `inst=0x00A00093`, `inst_pc=0x0`.
  - Cycle 7: `inst=0x01400113`, `inst_pc=0x4`.
  - Cycle 11: `inst=0x00A00193`.
- **Backpressure.** Hold `inst_ready=0` for 5 cycles while the first word is valid.
  - `inst` stays `0x00A00093`, `inst_valid` stays 1, `mem_ena/mem_enb` stay 0.
  - After `inst_ready` rises, the next word `0x01400113` appears 4 cycles after the handshake.
- **Redirect mid-fetch.** Pulse `redirect_valid` with `redirect_pc=0x58` during ISSUE_HI.
  - No word for PC 0x4 is emitted.
  - 4 cycles later: `inst=0x01E00613`, `inst_pc=0x58`.
- **Misaligned redirect.** Pulse redirect with `redirect_pc=0x5A`.
  - `misalign_err` is high for exactly 1 cycle.
  - Fetched word is `inst=0x01E00613`, `inst_pc=0x58`.
- **Wrap.** Redirect to `0xFFC`.
  - `inst=0x00000013`, `inst_pc=0xFFC`.
  - Next word: `inst=0x00A00093`, `inst_pc=0x1000`, with `mem_addra=0x000` during its ISSUE_LO.
- **Reset during COLLECT, and redirect plus handshake in VALID.**
  - Assert `rst` during COLLECT: the next cycle has `inst_valid=0` and `inst=0x00000013`, and fetch restarts at `RESET_PC`.
  - Assert redirect to `0x58` together with a VALID handshake: the word is accepted once, and the next word comes from `0x58`.
